// File: rtl/clock_enable_pkg.sv
// Shared types, constants and the window-end helper for clock_enable_gen.
package clock_enable_pkg;

    localparam int CNT_W_DEF = 16;

    // Width used by the end/full helper; callers cast their CNT_W values to it.
    localparam int CALC_W = 32;

    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    typedef struct packed {
        logic [CALC_W-1:0] end_v;
        logic              full;
    } end_full_t;

    // End point of an enable window, wrapped into the period, plus a flag for
    // windows at least one full period wide (those never clear).
    function automatic end_full_t calc_end_full(
        input logic [CALC_W-1:0] phase,
        input logic [CALC_W-1:0] width,
        input logic [CALC_W-1:0] period
    );
        logic [CALC_W:0] sum;
        logic [CALC_W:0] span;
        end_full_t       r;
        sum    = {1'b0, phase} + {1'b0, width};
        span   = {1'b0, period} + {{CALC_W{1'b0}}, 1'b1};
        r.full = ({1'b0, width} >= span);
        if (sum > {1'b0, period}) begin
            sum = sum - span;
        end
        r.end_v = sum[CALC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/clock_enable_chan.sv
// One enable channel: shadow phase/width/end/full and the registered enable.
module clock_enable_chan
    import clock_enable_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             apply_i,
    input  logic             kill_i,
    input  logic             step_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W-1:0] phase_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             en_o
);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] end_q;
    logic             full_q;
    logic             en_q;
    end_full_t        ef;

    // Derived window end for the configuration being applied this cycle.
    always_comb begin
        ef = calc_end_full(CALC_W'(phase_i), CALC_W'(width_i), CALC_W'(period_i));
    end

    // Shadow load on apply; otherwise set/clear against the shared counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= '0;
            width_q <= '0;
            end_q   <= '0;
            full_q  <= 1'b0;
            en_q    <= 1'b0;
        end else if (apply_i) begin
            phase_q <= phase_i;
            width_q <= width_i;
            end_q   <= CNT_W'(ef.end_v);
            full_q  <= ef.full;
            en_q    <= 1'b0;
        end else if (kill_i) begin
            en_q <= 1'b0;
        end else if (step_i) begin
            if (count_i == phase_q && width_q != '0) begin
                en_q <= 1'b1;
            end else if (count_i == end_q && !full_q) begin
                en_q <= 1'b0;
            end
        end
    end

    assign en_o = en_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: terminal counter, shadowed config
// applied on period boundaries, continuous or one-shot operation.
module clock_enable_gen
    import clock_enable_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    oneshot,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [NUM_CH*CNT_W-1:0] ch_phase,
    input  logic [NUM_CH*CNT_W-1:0] ch_width,
    output logic [NUM_CH-1:0]       clock_en,
    output logic                    tick,
    output logic [CNT_W-1:0]        count,
    output logic                    busy,
    output logic                    cfg_pending
);

    logic [CNT_W-1:0]        count_q,       count_d;
    logic [CNT_W-1:0]        period_q,      period_d;
    mode_e                   mode_q,        mode_d;
    logic                    done_q,        done_d;
    logic                    tick_q,        tick_d;
    logic                    busy_q,        busy_d;
    logic                    pend_q,        pend_d;
    logic [CNT_W-1:0]        pend_period_q, pend_period_d;
    mode_e                   pend_mode_q,   pend_mode_d;
    logic [NUM_CH*CNT_W-1:0] pend_phase_q,  pend_phase_d;
    logic [NUM_CH*CNT_W-1:0] pend_width_q,  pend_width_d;

    logic                    counting;
    logic                    wrap;
    logic                    os_end;
    logic                    use_pend;
    logic                    apply;
    logic                    capture;
    logic                    kill;
    logic [CNT_W-1:0]        src_period;
    mode_e                   src_mode;
    logic [NUM_CH*CNT_W-1:0] src_phase;
    logic [NUM_CH*CNT_W-1:0] src_width;

    // Event decode and next-state for counter, mode, pending and apply.
    always_comb begin
        counting   = run && !done_q;
        wrap       = counting && (count_q == period_q);
        os_end     = wrap && (mode_q == MODE_ONESHOT);
        // A load on the wrap edge itself wins over an older pending config.
        use_pend   = wrap && !cfg_load && pend_q;
        apply      = (cfg_load && !counting) || (wrap && cfg_load) || use_pend;
        capture    = cfg_load && counting && !wrap;
        kill       = !run || os_end;

        src_period = use_pend ? pend_period_q : cfg_period;
        src_mode   = use_pend ? pend_mode_q   : mode_e'(oneshot);
        src_phase  = use_pend ? pend_phase_q  : ch_phase;
        src_width  = use_pend ? pend_width_q  : ch_width;

        count_d    = (counting && !wrap) ? count_q + CNT_W'(1) : '0;
        done_d     = run && (done_q || os_end);
        tick_d     = wrap;
        busy_d     = counting && !os_end;
        pend_d     = apply ? 1'b0 : (capture ? 1'b1 : pend_q);

        period_d   = apply ? src_period : period_q;
        mode_d     = apply ? src_mode   : mode_q;

        pend_period_d = capture ? cfg_period       : pend_period_q;
        pend_mode_d   = capture ? mode_e'(oneshot) : pend_mode_q;
        pend_phase_d  = capture ? ch_phase         : pend_phase_q;
        pend_width_d  = capture ? ch_width         : pend_width_q;
    end

    // State registers; reset also discards any pending configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            period_q      <= '0;
            mode_q        <= MODE_CONT;
            done_q        <= 1'b0;
            tick_q        <= 1'b0;
            busy_q        <= 1'b0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            pend_mode_q   <= MODE_CONT;
            pend_phase_q  <= '0;
            pend_width_q  <= '0;
        end else begin
            count_q       <= count_d;
            period_q      <= period_d;
            mode_q        <= mode_d;
            done_q        <= done_d;
            tick_q        <= tick_d;
            busy_q        <= busy_d;
            pend_q        <= pend_d;
            pend_period_q <= pend_period_d;
            pend_mode_q   <= pend_mode_d;
            pend_phase_q  <= pend_phase_d;
            pend_width_q  <= pend_width_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clock_enable_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_i    (clk),
            .reset_i  (reset),
            .apply_i  (apply),
            .kill_i   (kill),
            .step_i   (counting),
            .count_i  (count_q),
            .phase_i  (src_phase[i*CNT_W +: CNT_W]),
            .width_i  (src_width[i*CNT_W +: CNT_W]),
            .period_i (src_period),
            .en_o     (clock_en[i])
        );
    end

    assign tick        = tick_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: stimulus queues hand-derived
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_clock_enable_gen;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           run;
    logic           oneshot;
    logic           cfg_load;
    logic [W-1:0]   cfg_period;
    logic [N*W-1:0] ch_phase;
    logic [N*W-1:0] ch_width;
    logic [N-1:0]   clock_en;
    logic           tick;
    logic [W-1:0]   count;
    logic           busy;
    logic           cfg_pending;

    clock_enable_gen #(.CNT_W(W), .NUM_CH(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .oneshot     (oneshot),
        .cfg_load    (cfg_load),
        .cfg_period  (cfg_period),
        .ch_phase    (ch_phase),
        .ch_width    (ch_width),
        .clock_en    (clock_en),
        .tick        (tick),
        .count       (count),
        .busy        (busy),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int           due;
        logic [W-1:0] cnt;
        logic [N-1:0] en;
        logic         tk;
        logic         bz;
        logic         pd;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_next(input string tag, input int c, input logic [N-1:0] e,
                               input logic t, input logic b, input logic p);
        exp_t x;
        x.due = ecnt + 1;
        x.cnt = W'(c);
        x.en  = e;
        x.tk  = t;
        x.bz  = b;
        x.pd  = p;
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input int per, input bit os, input int ph[N], input int wd[N]);
        cfg_period = W'(per);
        oneshot    = os;
        for (int i = 0; i < N; i++) begin
            ch_phase[i*W +: W] = W'(ph[i]);
            ch_width[i*W +: W] = W'(wd[i]);
        end
    endtask

    // Monitor: outputs are compared once per cycle, away from the rising edge.
    exp_t m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < ecnt) begin
            m = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s missed: due edge %0d, now edge %0d", m.tag, m.due, ecnt);
        end
        if (q.size() > 0 && q[0].due == ecnt) begin
            m = q.pop_front();
            checks++;
            if (count !== m.cnt || clock_en !== m.en || tick !== m.tk ||
                busy !== m.bz || cfg_pending !== m.pd) begin
                failures++;
                $display("FAIL %s edge %0d: got cnt=%0d en=%b tick=%b busy=%b pend=%b, want cnt=%0d en=%b tick=%b busy=%b pend=%b",
                         m.tag, ecnt, count, clock_en, tick, busy, cfg_pending,
                         m.cnt, m.en, m.tk, m.bz, m.pd);
            end
        end
    end

    initial begin
        int           ca;
        logic [N-1:0] e;
        int           guard;

        reset = 1'b1; run = 1'b0; oneshot = 1'b0; cfg_load = 1'b0;
        cfg_period = '0; ch_phase = '0; ch_width = '0;
        adv();
        adv();
        expect_next("reset", 0, '0, 0, 0, 0);
        adv();
        reset = 1'b0;

        // Tests 1-3 on one configuration, then test 5 (deferred apply).
        set_cfg(99, 0, '{98, 90, 5, 0}, '{1, 20, 0, 150});
        cfg_load = 1'b1;
        expect_next("load_idle", 0, '0, 0, 0, 0);
        adv();
        cfg_load = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (k == 240) begin
                set_cfg(49, 0, '{10, 0, 0, 0}, '{5, 0, 0, 0});
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            ca = (k + 1) % 100;
            e  = '0;
            if (k != 299) begin
                e[0] = (ca == 99);
                e[1] = (k >= 90) && (ca >= 91 || ca <= 10);
                e[3] = 1'b1;
            end
            expect_next("cont", ca, e, (k % 100) == 99, 1, (k >= 240) && (k < 299));
            adv();
        end
        cfg_load = 1'b0;
        for (int j = 0; j < 120; j++) begin
            ca = (j + 1) % 50;
            e  = '0;
            e[0] = (ca >= 11 && ca <= 15);
            expect_next("after_apply", ca, e, (j % 50) == 49, 1, 0);
            adv();
        end

        // Test 4: one-shot, run twice.
        run = 1'b0;
        expect_next("stop", 0, '0, 0, 0, 0);
        adv();
        set_cfg(9, 1, '{3, 0, 0, 0}, '{2, 0, 0, 0});
        cfg_load = 1'b1;
        expect_next("load_os", 0, '0, 0, 0, 0);
        adv();
        cfg_load = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            run = 1'b1;
            for (int k = 0; k < 20; k++) begin
                e = '0;
                if (k < 9) begin
                    e[0] = (k + 1 == 4) || (k + 1 == 5);
                    expect_next("oneshot", k + 1, e, 0, 1, 0);
                end else if (k == 9) begin
                    expect_next("os_wrap", 0, '0, 1, 0, 0);
                end else begin
                    expect_next("os_done", 0, '0, 0, 0, 0);
                end
                adv();
            end
            run = 1'b0;
            expect_next("os_stop", 0, '0, 0, 0, 0);
            adv();
        end

        // Test 6: reset mid-pulse with a pending config outstanding.
        set_cfg(99, 0, '{0, 90, 0, 0}, '{0, 20, 0, 0});
        cfg_load = 1'b1;
        expect_next("load_rst", 0, '0, 0, 0, 0);
        adv();
        cfg_load = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 96; k++) begin
            if (k == 93) begin
                set_cfg(5, 0, '{1, 1, 1, 1}, '{2, 2, 2, 2});
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            ca = k + 1;
            e  = '0;
            e[1] = (ca >= 91);
            expect_next("pre_rst", ca, e, 0, 1, k >= 93);
            adv();
        end
        cfg_load = 1'b0;
        reset = 1'b1;
        expect_next("mid_reset", 0, '0, 0, 0, 0);
        adv();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_next("post_reset", 0, '0, 1, 1, 0);
            adv();
        end

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            adv();
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
